// File: rtl/in_sync_buf_pkg.sv
// rtl/in_sync_buf_pkg.sv - shared sync-buffer helpers: Gray coding, pointer width, tag positions
`timescale 1ns/1ps
package in_sync_buf_pkg;

    localparam int PTR_MAX = 16;

    // Tags sit directly above the data word: {sof, eol, data}
    localparam int TAG_SOF_OFS = 1;
    localparam int TAG_EOL_OFS = 0;

    function automatic int addr_width(input int lines);
        return $clog2(lines) + 1;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/in_sync_buf_gray_ptr_sync.sv
// rtl/in_sync_buf_gray_ptr_sync.sv - carries a binary pointer across clock domains via Gray code
`timescale 1ns/1ps
module gray_ptr_sync
    import in_sync_buf_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk_src,
    input  logic         clk_dst,
    input  logic         rst_n,
    input  logic [W-1:0] bin_next,
    output logic [W-1:0] bin_out
);

    logic [PTR_MAX-1:0] gray_full;
    logic [PTR_MAX-1:0] bin_full;
    logic [W-1:0]       gray_q;
    logic [W-1:0]       gray_s;
    logic               unused_hi;

    // Encoding the next pointer keeps the Gray register in step with the binary one
    assign gray_full = bin2gray(PTR_MAX'(bin_next));

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) gray_q <= '0;
        else        gray_q <= gray_full[W-1:0];
    end

    genvar i;
    for (i = 0; i < W; i++) begin : g_sync
        sync_cell u_cell (.clk(clk_dst), .rst_n(rst_n), .d(gray_q[i]), .q(gray_s[i]));
    end

    assign bin_full  = gray2bin(PTR_MAX'(gray_s));
    assign unused_hi = ^{gray_full[PTR_MAX-1:W], bin_full[PTR_MAX-1:W]};

    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) bin_out <= '0;
        else        bin_out <= bin_full[W-1:0];
    end

endmodule

// File: rtl/sync_cell.sv
// rtl/sync_cell.sv - two-flop single-bit synchronizer
`timescale 1ns/1ps
module sync_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sync_dp_ram.sv
// rtl/sync_dp_ram.sv - simple dual-port RAM, independent clocks, registered read
`timescale 1ns/1ps
module sync_dp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk_wr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clk_rd,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_wr) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_rd) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/in_sync_buf.sv
// rtl/in_sync_buf.sv - encoder input CDC buffer tagging words with start-of-frame/end-of-line
`timescale 1ns/1ps
module in_sync_buf
    import in_sync_buf_pkg::*;
#(
    parameter int NUMBER_OF_LINES = 4,
    parameter int DATA_WIDTH      = 168,
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                               clk_wr,
    input  logic                               clk_rd,
    input  logic                               rst_n,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_valid,
    input  logic                               in_sof,
    output logic                               in_ready,
    output logic                               overflow,
    input  logic                               out_rd_en,
    output logic                               empty,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    output logic                               out_sof,
    output logic                               out_eol
);

    localparam int AW = addr_width(NUMBER_OF_LINES);
    localparam int SW = $clog2(MAX_SLICE_WIDTH);
    localparam int CW = SW - 2;
    localparam int RW = DATA_WIDTH + 2;

    logic [AW-1:0]   addr_w, addr_w_next, rptr_wr;
    logic [AW-1:0]   addr_r, addr_r_next, wptr_rd;
    logic [CW-1:0]   col, col_idx, col_last;
    logic [AW-2:0]   rd_addr_q;
    logic [RW-1:0]   ram_q;
    logic            full_wr, wr_en, eol, rd_en;
    logic            ram_req, out_req;
    logic            unused_sw_lsb;

    assign unused_sw_lsb = ^slice_width[1:0];

    assign full_wr     = (addr_w[AW-2:0] == rptr_wr[AW-2:0]) && (addr_w[AW-1] != rptr_wr[AW-1]);
    assign in_ready    = ~full_wr;
    assign wr_en       = in_valid & in_ready;
    assign addr_w_next = addr_w + AW'(wr_en);

    // A start-of-frame word is always column 0 of its line
    assign col_last = slice_width[SW-1:2] - CW'(1);
    assign col_idx  = in_sof ? '0 : col;
    assign eol      = (col_idx == col_last);

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            addr_w   <= '0;
            col      <= '0;
            overflow <= 1'b0;
        end else begin
            addr_w <= addr_w_next;
            if (wr_en) col <= eol ? '0 : col_idx + CW'(1);
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    assign empty       = (addr_r == wptr_rd);
    assign rd_en       = out_rd_en & ~empty;
    assign addr_r_next = addr_r + AW'(rd_en);

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            rd_addr_q <= '0;
            ram_req   <= 1'b0;
            out_req   <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            addr_r    <= addr_r_next;
            if (rd_en) rd_addr_q <= addr_r[AW-2:0];
            ram_req   <= rd_en;
            out_req   <= ram_req;
            out_valid <= out_req;
            out_sof   <= out_req & ram_q[DATA_WIDTH+TAG_SOF_OFS];
            out_eol   <= out_req & ram_q[DATA_WIDTH+TAG_EOL_OFS];
        end
    end

    // Data path is left unreset; only the qualifiers above carry meaning
    always_ff @(posedge clk_rd) begin
        if (out_req) out_data <= ram_q[DATA_WIDTH-1:0];
    end

    sync_dp_ram #(.WIDTH(RW), .DEPTH(NUMBER_OF_LINES), .AW(AW-1)) u_ram (
        .clk_wr (clk_wr),
        .wr_en  (wr_en),
        .wr_addr(addr_w[AW-2:0]),
        .wr_data({in_sof, eol, in_data}),
        .clk_rd (clk_rd),
        .rd_en  (ram_req),
        .rd_addr(rd_addr_q),
        .rd_data(ram_q)
    );

    gray_ptr_sync #(.W(AW)) u_wptr_sync (
        .clk_src (clk_wr),
        .clk_dst (clk_rd),
        .rst_n   (rst_n),
        .bin_next(addr_w_next),
        .bin_out (wptr_rd)
    );

    gray_ptr_sync #(.W(AW)) u_rptr_sync (
        .clk_src (clk_rd),
        .clk_dst (clk_wr),
        .rst_n   (rst_n),
        .bin_next(addr_r_next),
        .bin_out (rptr_wr)
    );

endmodule

// File: tb/tb_in_sync_buf.sv
// tb/tb_in_sync_buf.sv - directed self-checking bench for in_sync_buf
`timescale 1ns/1ps
module tb_in_sync_buf;

    localparam int DW = 168;

    logic          clk_wr = 1'b0;
    logic          clk_rd = 1'b0;
    logic          rst_n  = 1'b0;
    logic [11:0]   slice_width = 12'd16;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic          overflow;
    logic          out_rd_en = 1'b0;
    logic          empty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;

    real hp_wr = 5.0;
    real hp_rd = 3.333;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [DW-1:0] d; logic s; logic e; } word_t;
    word_t         got_q[$];
    logic [DW-1:0] wdat[16];
    logic          wsof[16];
    logic          weol[16];

    in_sync_buf #(.NUMBER_OF_LINES(4), .DATA_WIDTH(DW), .MAX_SLICE_WIDTH(2560)) dut (
        .clk_wr(clk_wr), .clk_rd(clk_rd), .rst_n(rst_n), .slice_width(slice_width),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .overflow(overflow), .out_rd_en(out_rd_en), .empty(empty), .out_data(out_data),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol)
    );

    initial forever #(hp_wr) clk_wr = ~clk_wr;
    initial begin
        #0.7;
        forever #(hp_rd) clk_rd = ~clk_rd;
    end

    always @(posedge clk_rd) begin
        #1;
        if (out_valid === 1'b1) got_q.push_back('{d: out_data, s: out_sof, e: out_eol});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic apply_reset(input logic [11:0] sw);
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_rd_en = 1'b0; slice_width = sw;
        #30;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_wr);
        #1;
        got_q.delete();
    endtask

    task automatic write_seq(input int n);
        int guard;
        @(posedge clk_wr); #1;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!in_ready && guard < 500) begin @(posedge clk_wr); #1; guard++; end
            if (guard >= 500) begin checks++; errors++; $display("FAIL write_timeout: word %0d never accepted", i); end
            in_data = wdat[i]; in_sof = wsof[i]; in_valid = 1'b1;
            @(posedge clk_wr); #1;
            in_valid = 1'b0; in_sof = 1'b0;
        end
    endtask

    task automatic read_n(input int n);
        int cnt = 0;
        int guard = 0;
        @(posedge clk_rd); #1;
        out_rd_en = 1'b1;
        while (cnt < n && guard < 2000) begin
            if (!empty) cnt++;
            @(posedge clk_rd); #1;
            guard++;
        end
        out_rd_en = 1'b0;
        if (cnt < n) begin checks++; errors++; $display("FAIL read_timeout: got %0d reads expected %0d", cnt, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; slice_width = 12'd16;
        #12;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        checks++; if (out_sof !== 1'b0)   begin errors++; $display("FAIL rst_out_sof: got %b expected 0", out_sof); end
        checks++; if (out_eol !== 1'b0)   begin errors++; $display("FAIL rst_out_eol: got %b expected 0", out_eol); end
        rst_n = 1'b1;
        repeat (20) @(posedge clk_wr);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL idle_empty: got %b expected 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL idle_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_single_word();
        int n = 0;
        apply_reset(12'd16);
        @(posedge clk_wr); #1;
        in_data = DW'(32'hA5); in_sof = 1'b1; in_valid = 1'b1;
        @(posedge clk_wr);
        fork begin #1; in_valid = 1'b0; in_sof = 1'b0; end join_none
        while (empty && n < 10) begin @(posedge clk_rd); n++; #1; end
        checks++; if (!(n >= 3 && n <= 4)) begin errors++; $display("FAIL single_empty_latency: got %0d edges expected 3..4", n); end
        out_rd_en = 1'b1;
        @(posedge clk_rd); #1;
        out_rd_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0: got %b expected 0", out_valid); end
        @(posedge clk_rd); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1: got %b expected 0", out_valid); end
        @(posedge clk_rd); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2: got %b expected 1", out_valid); end
        checks++; if (out_data !== DW'(32'hA5)) begin errors++; $display("FAIL single_data: got %0h expected a5", out_data); end
        checks++; if (out_sof !== 1'b1) begin errors++; $display("FAIL single_sof: got %b expected 1", out_sof); end
        checks++; if (out_eol !== 1'b0) begin errors++; $display("FAIL single_eol: got %b expected 0", out_eol); end
        @(posedge clk_rd); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_once: got %b expected 0", out_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", empty); end
    endtask

    task automatic test_full_overflow();
        int n = 0;
        apply_reset(12'd16);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = DW'(32'h200 + i); wsof[i] = (i == 0); weol[i] = (i == 3);
        end
        write_seq(4);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        in_data = DW'(32'hDEAD); in_valid = 1'b1;
        repeat (3) @(posedge clk_wr);
        #1;
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_still_full: got %b expected 0", in_ready); end
        @(posedge clk_rd); #1;
        out_rd_en = 1'b1;
        @(posedge clk_rd);
        fork begin #1; out_rd_en = 1'b0; end join_none
        while (!in_ready && n < 10) begin @(posedge clk_wr); n++; #1; end
        checks++; if (!(n >= 3 && n <= 4)) begin errors++; $display("FAIL full_ready_latency: got %0d edges expected 3..4", n); end
        read_n(3);
        repeat (8) @(posedge clk_rd);
        #1;
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL full_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== wdat[i] || got_q[i].s !== wsof[i] || got_q[i].e !== weol[i]) begin
                errors++;
                $display("FAIL full_word%0d: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, wdat[i], wsof[i], weol[i]);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_stream();
        apply_reset(12'd16);
        for (int i = 0; i < 8; i++) begin
            wdat[i] = DW'(32'h300 + i); wsof[i] = (i == 0); weol[i] = (i == 3 || i == 7);
        end
        fork
            write_seq(8);
            read_n(8);
        join
        repeat (8) @(posedge clk_rd);
        #1;
        checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== wdat[i] || got_q[i].s !== wsof[i] || got_q[i].e !== weol[i]) begin
                errors++;
                $display("FAIL stream_word%0d: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, wdat[i], wsof[i], weol[i]);
            end
        end
    endtask

    task automatic test_sof_restart();
        got_q.delete();
        for (int i = 0; i < 7; i++) begin
            wdat[i] = DW'(32'h400 + i); wsof[i] = (i == 0 || i == 2); weol[i] = (i == 5);
        end
        fork
            write_seq(7);
            read_n(7);
        join
        repeat (8) @(posedge clk_rd);
        #1;
        checks++; if (got_q.size() !== 7) begin errors++; $display("FAIL restart_count: got %0d expected 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== wdat[i] || got_q[i].s !== wsof[i] || got_q[i].e !== weol[i]) begin
                errors++;
                $display("FAIL restart_word%0d: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, wdat[i], wsof[i], weol[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        hp_wr = 6.667; hp_rd = 2.5;
        apply_reset(12'd16);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = DW'(32'h500 + i); wsof[i] = (i == 0); weol[i] = (i == 3);
        end
        write_seq(4);
        while (empty && n < 20) begin @(posedge clk_rd); n++; #1; end
        out_rd_en = 1'b1;
        repeat (3) @(posedge clk_rd);
        #1;
        #0.3;
        rst_n = 1'b0;
        #0.2;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        out_rd_en = 1'b0;
        apply_reset(12'd16);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = DW'(32'h600 + i); wsof[i] = (i == 0); weol[i] = (i == 3);
        end
        fork
            write_seq(4);
            read_n(4);
        join
        repeat (8) @(posedge clk_rd);
        #1;
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== wdat[i] || got_q[i].s !== wsof[i] || got_q[i].e !== weol[i]) begin
                errors++;
                $display("FAIL midrst_word%0d: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, wdat[i], wsof[i], weol[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_overflow();
        test_stream();
        test_sof_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
